// File: rtl/robo_pkg.sv
// robo_pkg: shared definitions for the collector robot (controller, executor,
// sensor model). Holds the heading encoding, the executor FSM state enum,
// coordinate/counter widths and small helper functions.
package robo_pkg;

  localparam int COORD_W = 5;  // row/column width
  localparam int CNT_W   = 8;  // move/collect counter width

  // Heading encoding: N=00 S=01 L(east)=10 O(west)=11
  typedef enum logic [1:0] {
    HEAD_N = 2'b00,
    HEAD_S = 2'b01,
    HEAD_L = 2'b10,
    HEAD_O = 2'b11
  } heading_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_ROTATE = 3'd2,
    ST_GRAB   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Rotate 90 degrees counter-clockwise: N->O->S->L->N
  function automatic heading_t turn_left(input heading_t h);
    heading_t r;
    case (h)
      HEAD_N:  r = HEAD_O;
      HEAD_O:  r = HEAD_S;
      HEAD_S:  r = HEAD_L;
      default: r = HEAD_N;
    endcase
    return r;
  endfunction

  // Counter increment that holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/robo_executor_if.sv
// robo_executor_if: command/status bundle between the robot controller
// (master) and the actuation executor (slave).
//
// Handshake: the executor samples advance/turn/collect on a rising edge only
// while busy=0. Once a command is taken busy stays high for the whole
// command including its one-cycle done pulse; commands presented while
// busy=1 are dropped, never queued. Pose and counters are valid while done=1
// and throughout idle.
interface robo_executor_if;
  import robo_pkg::*;

  logic                advance;
  logic                turn;
  logic                collect;
  logic                motor_fwd;
  logic                motor_rot;
  logic                claw;
  logic                busy;
  logic                done;
  logic [COORD_W-1:0]  linha;
  logic [COORD_W-1:0]  coluna;
  logic [1:0]          orientacao;
  logic [CNT_W-1:0]    qtd_movimentos;
  logic [CNT_W-1:0]    qtd_coletas;
  logic                fora_mapa;

  modport master (
    output advance, turn, collect,
    input  motor_fwd, motor_rot, claw, busy, done,
    input  linha, coluna, orientacao, qtd_movimentos, qtd_coletas, fora_mapa
  );

  modport slave (
    input  advance, turn, collect,
    output motor_fwd, motor_rot, claw, busy, done,
    output linha, coluna, orientacao, qtd_movimentos, qtd_coletas, fora_mapa
  );

endinterface

// File: rtl/robo_pose.sv
// robo_pose: robot pose register (row, column, heading) with map boundary
// check.
// Ports:
//   clock, reset      : system clock, async active-low reset
//   step              : one-cycle strobe, apply the command below
//   step_turn         : 1 = rotate left, 0 = advance one cell
//   row, col, head    : registered pose
//   adv_blocked       : an advance from the current pose would leave the map
module robo_pose
  import robo_pkg::*;
#(
  parameter int ROWS      = 20,
  parameter int COLS      = 20,
  parameter int START_ROW = 4,
  parameter int START_COL = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               step,
  input  logic               step_turn,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output heading_t           head,
  output logic               adv_blocked
);

  // Blocked when the target cell would be <1 or beyond the map edge
  always_comb begin
    adv_blocked = 1'b0;
    case (head)
      HEAD_N:  adv_blocked = (row <= COORD_W'(1));
      HEAD_S:  adv_blocked = (row >= COORD_W'(ROWS));
      HEAD_L:  adv_blocked = (col >= COORD_W'(COLS));
      default: adv_blocked = (col <= COORD_W'(1));
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row  <= COORD_W'(START_ROW);
      col  <= COORD_W'(START_COL);
      head <= HEAD_N;
    end else if (step) begin
      if (step_turn) begin
        head <= turn_left(head);
      end else if (!adv_blocked) begin
        case (head)
          HEAD_N:  row <= row - 1'b1;
          HEAD_S:  row <= row + 1'b1;
          HEAD_L:  col <= col + 1'b1;
          default: col <= col - 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/robo_executor.sv
// robo_executor: actuation stage of the collector robot. Takes one
// advance/turn/collect decision at a time, drives the matching actuator for
// a fixed number of cycles, then emits a one-cycle done pulse with the pose
// and counters already updated.
// Ports:
//   clock, reset : system clock, async active-low reset
//   bus          : command/status bundle (slave side)
//   dbg_state    : current FSM state
module robo_executor
  import robo_pkg::*;
#(
  parameter int MOVE_CYCLES    = 4,
  parameter int TURN_CYCLES    = 2,
  parameter int COLLECT_CYCLES = 3,
  parameter int ROWS           = 20,
  parameter int COLS           = 20,
  parameter int START_ROW      = 4,
  parameter int START_COL      = 3
) (
  input  logic           clock,
  input  logic           reset,
  robo_executor_if.slave bus,
  output state_t         dbg_state
);

  localparam int CW = 16;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                at_end;
  logic                motor_fwd_q, motor_rot_q, claw_q, busy_q, done_q;
  logic [CNT_W-1:0]    mov_q, col_q;
  logic                off_q;
  logic                step, step_turn, adv_blocked;
  logic [COORD_W-1:0]  row, col;
  heading_t            head;

  // Last actuator cycle of the current command
  always_comb begin
    at_end = 1'b0;
    case (state)
      ST_MOVE:   at_end = (cnt == CW'(MOVE_CYCLES - 1));
      ST_ROTATE: at_end = (cnt == CW'(TURN_CYCLES - 1));
      ST_GRAB:   at_end = (cnt == CW'(COLLECT_CYCLES - 1));
      default:   at_end = 1'b0;
    endcase
  end

  // Pose moves on the same edge that enters FINISH
  assign step      = at_end && ((state == ST_MOVE) || (state == ST_ROTATE));
  assign step_turn = (state == ST_ROTATE);

  robo_pose #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .START_ROW (START_ROW),
    .START_COL (START_COL)
  ) u_pose (
    .clock       (clock),
    .reset       (reset),
    .step        (step),
    .step_turn   (step_turn),
    .row         (row),
    .col         (col),
    .head        (head),
    .adv_blocked (adv_blocked)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      motor_fwd_q <= 1'b0;
      motor_rot_q <= 1'b0;
      claw_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mov_q       <= '0;
      col_q       <= '0;
      off_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // collect > advance > turn
          if (bus.collect) begin
            state  <= ST_GRAB;
            claw_q <= 1'b1;
            busy_q <= 1'b1;
          end else if (bus.advance) begin
            state       <= ST_MOVE;
            motor_fwd_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (bus.turn) begin
            state       <= ST_ROTATE;
            motor_rot_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_MOVE, ST_ROTATE, ST_GRAB: begin
          if (at_end) begin
            state       <= ST_FINISH;
            cnt         <= '0;
            motor_fwd_q <= 1'b0;
            motor_rot_q <= 1'b0;
            claw_q      <= 1'b0;
            done_q      <= 1'b1;
            case (state)
              ST_MOVE: begin
                if (adv_blocked) off_q <= 1'b1;
                else             mov_q <= sat_inc(mov_q);
              end
              ST_ROTATE: mov_q <= sat_inc(mov_q);
              default:   col_q <= sat_inc(col_q);
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          motor_fwd_q <= 1'b0;
          motor_rot_q <= 1'b0;
          claw_q      <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.motor_fwd      = motor_fwd_q;
  assign bus.motor_rot      = motor_rot_q;
  assign bus.claw           = claw_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.linha          = row;
  assign bus.coluna         = col;
  assign bus.orientacao     = head;
  assign bus.qtd_movimentos = mov_q;
  assign bus.qtd_coletas    = col_q;
  assign bus.fora_mapa      = off_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_robo_executor.sv
module tb_robo_executor;
  import robo_pkg::*;

  localparam int MOVE_N = 4, TURN_N = 2, COLL_N = 3, ROWS = 20, COLS = 20;

  logic   clock;
  logic   reset;
  state_t dbg_state;
  int     total, bad;

  robo_executor_if bus ();

  robo_executor dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int m_row, m_col, m_head, m_mov, m_coll;
  bit m_off;
  int left_of [4] = '{3, 2, 0, 1};  // N->O, S->L, L->N, O->S

  task automatic model_reset();
    m_row = 4; m_col = 3; m_head = 0; m_mov = 0; m_coll = 0; m_off = 0;
  endtask

  task automatic model_apply(input bit a, input bit t, input bit c);
    int nr, nc;
    if (c) begin
      if (m_coll < 255) m_coll++;
    end else if (a) begin
      nr = m_row + ((m_head == 0) ? -1 : (m_head == 1) ? 1 : 0);
      nc = m_col + ((m_head == 2) ? 1 : (m_head == 3) ? -1 : 0);
      if (nr < 1 || nr > ROWS || nc < 1 || nc > COLS) m_off = 1;
      else begin
        m_row = nr; m_col = nc;
        if (m_mov < 255) m_mov++;
      end
    end else if (t) begin
      m_head = left_of[m_head];
      if (m_mov < 255) m_mov++;
    end
  endtask

  // ---------------- driver + per-command checks ----------------
  // Issue one command while idle, follow it to done, check pulse widths,
  // exclusivity, done behaviour and the resulting pose/counters.
  task automatic run_cmd(input bit a, input bit t, input bit c, input bit toggle_turn);
    int exp_n, fwd_n, rot_n, claw_n, guard;
    bit seen_done;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 50) begin
      @(posedge clock); #1; guard++;
    end
    bus.advance = a; bus.turn = t; bus.collect = c;
    @(posedge clock); #1;
    bus.advance = 0; bus.turn = 0; bus.collect = 0;
    if (!(a || t || c)) begin
      total++;
      if (bus.busy !== 1'b0) begin
        bad++; $display("FAIL idle_busy: got %0b expected 0", bus.busy);
      end
      return;
    end
    exp_n = c ? COLL_N : (a ? MOVE_N : TURN_N);
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL busy_start: got %0b expected 1", bus.busy);
    end
    fwd_n = 0; rot_n = 0; claw_n = 0; seen_done = 0; guard = 0;
    while (!seen_done && guard < 40) begin
      if (bus.motor_fwd === 1'b1) fwd_n++;
      if (bus.motor_rot === 1'b1) rot_n++;
      if (bus.claw === 1'b1) claw_n++;
      if ((int'(bus.motor_fwd) + int'(bus.motor_rot) + int'(bus.claw)) > 1) begin
        total++; bad++;
        $display("FAIL one_hot: fwd=%0b rot=%0b claw=%0b", bus.motor_fwd, bus.motor_rot, bus.claw);
      end
      if (bus.done === 1'b1) begin
        seen_done = 1;
        bus.turn = 0;
      end else begin
        if (toggle_turn) bus.turn = ~bus.turn;
        @(posedge clock); #1;
      end
      guard++;
    end
    total++;
    if (!seen_done) begin
      bad++; $display("FAIL done_timeout: got no done within %0d cycles", guard);
      return;
    end
    model_apply(a, t, c);
    total++;
    if (fwd_n !== (c ? 0 : (a ? exp_n : 0)) || rot_n !== ((!c && !a) ? exp_n : 0) ||
        claw_n !== (c ? exp_n : 0)) begin
      bad++;
      $display("FAIL pulse_len: fwd=%0d rot=%0d claw=%0d expected %0d on a=%0b t=%0b c=%0b",
               fwd_n, rot_n, claw_n, exp_n, a, t, c);
    end
    total++;
    if (bus.busy !== 1'b1 || bus.motor_fwd !== 1'b0 || bus.motor_rot !== 1'b0 || bus.claw !== 1'b0) begin
      bad++; $display("FAIL finish_outs: busy=%0b fwd=%0b rot=%0b claw=%0b expected 1 0 0 0",
                      bus.busy, bus.motor_fwd, bus.motor_rot, bus.claw);
    end
    total++;
    if (int'(bus.linha) !== m_row || int'(bus.coluna) !== m_col || int'(bus.orientacao) !== m_head) begin
      bad++; $display("FAIL pose: got r=%0d c=%0d h=%0d expected r=%0d c=%0d h=%0d",
                      bus.linha, bus.coluna, bus.orientacao, m_row, m_col, m_head);
    end
    total++;
    if (int'(bus.qtd_movimentos) !== m_mov || int'(bus.qtd_coletas) !== m_coll || bus.fora_mapa !== m_off) begin
      bad++; $display("FAIL counters: got mov=%0d coll=%0d off=%0b expected mov=%0d coll=%0d off=%0b",
                      bus.qtd_movimentos, bus.qtd_coletas, bus.fora_mapa, m_mov, m_coll, m_off);
    end
    @(posedge clock); #1;
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL back_idle: done=%0b busy=%0b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (bus.motor_fwd !== 0 || bus.motor_rot !== 0 || bus.claw !== 0 || bus.busy !== 0 ||
        bus.done !== 0 || bus.linha !== 5'd4 || bus.coluna !== 5'd3 || bus.orientacao !== 2'b00 ||
        bus.qtd_movimentos !== 8'd0 || bus.qtd_coletas !== 8'd0 || bus.fora_mapa !== 0) begin
      bad++;
      $display("FAIL %s: fwd=%0b rot=%0b claw=%0b busy=%0b done=%0b r=%0d c=%0d h=%0d mov=%0d coll=%0d off=%0b expected all 0, r=4 c=3",
               tag, bus.motor_fwd, bus.motor_rot, bus.claw, bus.busy, bus.done, bus.linha,
               bus.coluna, bus.orientacao, bus.qtd_movimentos, bus.qtd_coletas, bus.fora_mapa);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 0; bus.advance = 0; bus.turn = 0; bus.collect = 0;
    repeat (3) @(posedge clock);
    #1 check_reset_values("reset_values");
    @(negedge clock) reset = 1;
    model_reset();
    @(posedge clock); #1;
    check_reset_values("after_release");
  endtask

  task automatic test_advance();
    run_cmd(1, 0, 0, 0);   // row 4 -> 3
  endtask

  task automatic test_turns();
    for (int i = 0; i < 4; i++) run_cmd(0, 1, 0, 0);  // O, S, L, N
  endtask

  task automatic test_priority();
    run_cmd(1, 1, 1, 0);   // collect wins
  endtask

  task automatic test_off_map();
    while (m_row > 1) run_cmd(1, 0, 0, 0);
    run_cmd(1, 0, 0, 0);   // off the top edge
    run_cmd(1, 0, 0, 0);   // sticky flag stays set
  endtask

  task automatic test_busy_ignore();
    run_cmd(0, 1, 0, 0);   // face west
    run_cmd(1, 0, 0, 1);   // turn toggles while moving
  endtask

  task automatic test_random();
    bit a, t, c;
    for (int i = 0; i < 40; i++) begin
      a = bit'($urandom_range(0, 1));
      t = bit'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) == 0);
      run_cmd(a, t, c, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    bus.advance = 1;
    @(posedge clock); #1;
    bus.advance = 0;
    @(posedge clock); #1;   // second MOVE cycle
    total++;
    if (bus.motor_fwd !== 1'b1) begin
      bad++; $display("FAIL mid_move: got %0b expected 1", bus.motor_fwd);
    end
    #2 reset = 0;
    #1 check_reset_values("mid_reset");
    model_reset();
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    check_reset_values("mid_release");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) run_cmd(0, 1, 0, 0);
    total++;
    if (bus.qtd_movimentos !== 8'd255) begin
      bad++; $display("FAIL saturate: got %0d expected 255", bus.qtd_movimentos);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_advance();
    test_turns();
    test_priority();
    test_off_map();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
